row_draw_ctrl: RTL and testbench
================================

ROW_DRAW_CTRL -- requirements
Module: row_draw_ctrl

Interface
REQ-001 Parameter X_ORIGIN, default 10: screen x of slot 0's left edge in row 0.
REQ-002 Parameter Y_ORIGIN, default 10: screen y of row 0's top edge.
REQ-003 Parameter SLOT_PITCH, default 30: x distance between slot left edges.
REQ-004 Parameter ROW_PITCH, default 24: y distance between row top edges.
REQ-005 clock  in  1  single system clock (50 MHz); all state on its rising edge.
REQ-006 resetn  in  1  reset; asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to draw one guess row.
REQ-008 erase  in  1  sampled with start; 1 = paint all four squares colour 3'b000.
REQ-009 row  in  4  guess row index, legal 0..9.
REQ-010 code  in  12  four 3-bit slot colours; slot s = code[3s+2:3s].
REQ-011 busy  out  1  high from accepted start until the cycle before done.
REQ-012 plot  out  1  pixel write strobe to the VGA adapter.
REQ-013 x  out  9  pixel x coordinate.
REQ-014 y  out  8  pixel y coordinate.
REQ-015 colour  out  3  pixel colour.
REQ-016 done  out  1  one-cycle pulse after last pixel of a row.
REQ-017 err  out  1  one-cycle pulse when start is rejected for row > 9.

Function
REQ-018 FSM has three states: IDLE, DRAW, DONE.
REQ-019 In IDLE, start=1 with row<=9 latches row, code, erase and enters DRAW on the same edge with slot=0, px=0, py=0.
REQ-020 In IDLE, start=1 with row>9 stays in IDLE and pulses err for exactly one cycle; nothing plotted.
REQ-021 start is ignored in DRAW and DONE; latched values remain stable for the whole row.
REQ-022 In DRAW, plot=1 every cycle; x = X_ORIGIN + slot*SLOT_PITCH + px; y = Y_ORIGIN + row*ROW_PITCH + py.
REQ-023 Scan order: px 0..19 fastest, then py 0..19, then slot 0..3; 400 pixels per square, 1600 plot cycles per row.
REQ-024 colour = 3'b000 if latched erase, else latched code slice for current slot.
REQ-025 After the plot cycle with slot=3, py=19, px=19, FSM enters DONE; DONE lasts one cycle with done=1, plot=0, then returns to IDLE.
REQ-026 start in the DONE cycle is ignored; earliest accepted restart is the first IDLE cycle.
REQ-027 busy=1 exactly in DRAW; plot=0, x=0, y=0, colour=0 outside DRAW.
REQ-028 Coordinate arithmetic is unsigned, computed at 10 bits and truncated to port width; default parameters never exceed x=119, y=245.
REQ-029 No division or modulo operators; px/py/slot are separate wrapping counters.

Reset
REQ-030 resetn=0 asynchronously forces IDLE, counters 0, latched row/code/erase 0, and all outputs 0.
REQ-031 Reset asserted mid-DRAW aborts the row immediately; no done pulse is produced; after release the block waits in IDLE for a new start.

Structure
REQ-032 Shared package mm_draw_pkg holds the FSM state encoding, SQUARE_SIZE=20, NUM_SLOTS=4, NUM_ROWS=10 and colour constant COLOUR_BLACK=3'b000.
REQ-033 One sub-module, square_scan (px/py counters with enable, advance and last-pixel flag), is instantiated once; slot counter and FSM live in row_draw_ctrl.

Verification
REQ-034 Reset then start, row=0, code=12'b011_010_001_100, erase=0 -> first plot (10,10,3'b100); plot (40,10,3'b001) at plot cycle 400; final plot (119,29,3'b011) at plot cycle 1599; done one cycle later; exactly 1600 plots.
REQ-035 start, row=9, erase=1, code=12'hFFF -> all 1600 plots colour 0; y spans 226..245.
REQ-036 start, row=10 -> err pulse 1 cycle, busy stays 0, no plot, no done.
REQ-037 Second start pulse at plot cycle 500 with different code and row -> ignored; row completes with original values.
REQ-038 resetn pulsed low at plot cycle 800 -> outputs 0 asynchronously, no done; new start after release draws a full 1600-pixel row.
REQ-039 start held high continuously -> rows back-to-back with one DONE cycle and one IDLE cycle between them.

Source files
------------

// File: rtl/mm_draw_pkg.sv
// ============================================================================
// Module : mm_draw_pkg
// Brief  : Shared state encoding and geometry constants for row drawing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mm_draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         SQUARE_SIZE  = 20;
    localparam int         NUM_SLOTS    = 4;
    localparam int         NUM_ROWS     = 10;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

`default_nettype wire

// File: rtl/square_scan.sv
// ============================================================================
// Module : square_scan
// Brief  : Raster scan of one square: px fastest, then py, with last flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module square_scan
    import mm_draw_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    output logic [4:0] px,
    output logic [4:0] py,
    output logic       last
);

    localparam logic [4:0] LAST_IDX = 5'(SQUARE_SIZE - 1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (enable) begin
            if (px == LAST_IDX) begin
                px <= '0;
                py <= (py == LAST_IDX) ? 5'd0 : py + 5'd1;
            end else begin
                px <= px + 5'd1;
            end
        end
    end

    assign last = (px == LAST_IDX) && (py == LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/row_draw_ctrl.sv
// ============================================================================
// Module : row_draw_ctrl
// Brief  : Paints one guess row of four coloured squares through a VGA plotter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module row_draw_ctrl
    import mm_draw_pkg::*;
#(
    parameter int X_ORIGIN   = 10,
    parameter int Y_ORIGIN   = 10,
    parameter int SLOT_PITCH = 30,
    parameter int ROW_PITCH  = 24
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        erase,
    input  logic [3:0]  row,
    input  logic [11:0] code,
    output logic        busy,
    output logic        plot,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        done,
    output logic        err
);

    state_t                      state;
    state_t                      next_state;
    logic [3:0]                  row_lat;
    logic [NUM_SLOTS-1:0][2:0]   code_lat;
    logic                        erase_lat;
    logic [1:0]                  slot;
    logic                        err_q;
    logic [4:0]                  px;
    logic [4:0]                  py;
    logic                        last_px;
    logic                        row_ok;
    logic                        accept;
    logic                        reject;
    logic                        last_slot;

    assign row_ok    = (row <= 4'(NUM_ROWS - 1));
    assign accept    = (state == IDLE) && start && row_ok;
    assign reject    = (state == IDLE) && start && !row_ok;
    assign last_slot = (slot == 2'(NUM_SLOTS - 1));

    square_scan u_scan (
        .clock  (clock),
        .resetn (resetn),
        .clear  (accept),
        .enable (state == DRAW),
        .px     (px),
        .py     (py),
        .last   (last_px)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            row_lat   <= '0;
            code_lat  <= '0;
            erase_lat <= 1'b0;
            slot      <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= next_state;
            err_q <= reject;
            if (accept) begin
                row_lat   <= row;
                code_lat  <= code;
                erase_lat <= erase;
                slot      <= '0;
            end else if ((state == DRAW) && last_px) begin
                slot <= slot + 2'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = DRAW;
            DRAW:    if (last_px && last_slot) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decode straight from registered state so reset clears them at once.
    always_comb begin
        busy   = 1'b0;
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        done   = (state == DONE);
        err    = err_q;
        if (state == DRAW) begin
            busy   = 1'b1;
            plot   = 1'b1;
            x      = 9'(10'(X_ORIGIN) + 10'(slot) * 10'(SLOT_PITCH) + 10'(px));
            y      = 8'(10'(Y_ORIGIN) + 10'(row_lat) * 10'(ROW_PITCH) + 10'(py));
            colour = erase_lat ? COLOUR_BLACK : code_lat[slot];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_row_draw_ctrl.sv
// ============================================================================
// Module : tb_row_draw_ctrl
// Brief  : Scoreboard bench for row_draw_ctrl with a reference pixel model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_row_draw_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        erase = 1'b0;
    logic [3:0]  row = '0;
    logic [11:0] code = '0;
    logic        busy, plot, done, err;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;

    row_draw_ctrl dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .erase  (erase),
        .row    (row),
        .code   (code),
        .busy   (busy),
        .plot   (plot),
        .x      (x),
        .y      (y),
        .colour (colour),
        .done   (done),
        .err    (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;   // 0 plot, 1 done, 2 err
        int ex;
        int ey;
        int col;
        int gap;    // required quiet cycles before this event, -1 = any
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;
    int  plot_count = 0;
    int  done_count = 0;
    int  quiet = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: enumerate every pixel of the row in raster order.
    task automatic push_row(input int r, input int c, input bit e, input int first_gap);
        ev_t ev;
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 20; j++)
                for (int i = 0; i < 20; i++) begin
                    ev.kind = 0;
                    ev.ex   = (10 + s * 30 + i) % 512;
                    ev.ey   = (10 + r * 24 + j) % 256;
                    ev.col  = e ? 0 : ((c >> (3 * s)) & 7);
                    ev.gap  = (s == 0 && j == 0 && i == 0) ? first_gap : -1;
                    q.push_back(ev);
                end
        ev.kind = 1; ev.ex = 0; ev.ey = 0; ev.col = 0; ev.gap = 0;
        q.push_back(ev);
    endtask

    task automatic push_err();
        ev_t ev;
        ev.kind = 2; ev.ex = 0; ev.ey = 0; ev.col = 0; ev.gap = -1;
        q.push_back(ev);
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            ev_t e;
            int  k;
            chk("busy_eq_plot", int'(busy), int'(plot));
            if (!plot) chk("idle_outputs_zero", int'({x, y, colour}), 0);
            if (plot || done || err) begin
                k = plot ? 0 : (done ? 1 : 2);
                chk("single_event", int'(plot) + int'(done) + int'(err), 1);
                if (q.size() == 0) begin
                    chk("unexpected_event_kind", k, -1);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", k, e.kind);
                    if (e.kind == 0 && k == 0) begin
                        chk("x", int'(x), e.ex);
                        chk("y", int'(y), e.ey);
                        chk("colour", int'(colour), e.col);
                    end
                    if (e.gap >= 0) chk("gap_cycles", quiet, e.gap);
                end
                if (plot) plot_count++;
                if (done) done_count++;
                quiet = 0;
            end else begin
                quiet++;
            end
        end
    end

    task automatic do_start(input int r, input int c, input bit e);
        @(posedge clock); #1;
        start = 1'b1; row = 4'(r); code = 12'(c); erase = e;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(posedge clock);
            n++;
        end
        chk("queue_drained", q.size(), 0);
        q.delete();
        repeat (4) @(posedge clock);
    endtask

    task automatic wait_plots(input int target);
        int n = 0;
        while (plot_count < target && n < 4000) begin
            @(posedge clock);
            n++;
        end
        chk("reached_plot_count", int'(plot_count >= target), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_plot"}, int'(plot), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_xycol"}, int'({x, y, colour}), 0);
    endtask

    initial begin
        int base, dc;
        int r, c;
        bit e;

        repeat (3) @(posedge clock);
        #1 check_zero_outputs("reset");
        resetn = 1'b1;
        repeat (2) @(posedge clock);

        // Reference row with distinct slot colours.
        push_row(0, 12'b011_010_001_100, 1'b0, -1);
        do_start(0, 12'b011_010_001_100, 1'b0);
        wait_drain();

        // Erase of the last legal row.
        push_row(9, 12'hFFF, 1'b1, -1);
        do_start(9, 12'hFFF, 1'b1);
        wait_drain();

        // Illegal row: err only.
        push_err();
        do_start(10, 12'h123, 1'b0);
        wait_drain();

        // A second start mid-row must be ignored.
        base = plot_count;
        push_row(3, 12'h5A3, 1'b0, -1);
        do_start(3, 12'h5A3, 1'b0);
        wait_plots(base + 500);
        do_start(7, 12'h0F0, 1'b1);
        wait_drain();

        // Asynchronous reset mid-row aborts it without done.
        base = plot_count;
        push_row(5, 12'h9C6, 1'b0, -1);
        do_start(5, 12'h9C6, 1'b0);
        wait_plots(base + 800);
        @(posedge clock); #2;
        resetn = 1'b0;
        #1 check_zero_outputs("async_reset");
        q.delete();
        @(posedge clock); #1;
        check_zero_outputs("held_reset");
        resetn = 1'b1;
        repeat (5) @(posedge clock);
        push_row(6, 12'h2B7, 1'b0, -1);
        do_start(6, 12'h2B7, 1'b0);
        wait_drain();

        // Start held high: back-to-back rows separated by DONE plus one IDLE.
        push_row(2, 12'hE49, 1'b0, -1);
        push_row(2, 12'hE49, 1'b0, 1);
        @(posedge clock); #1;
        start = 1'b1; row = 4'd2; code = 12'hE49; erase = 1'b0;
        dc = done_count;
        base = 0;
        while (done_count == dc && base < 4000) begin
            @(posedge clock);
            base++;
        end
        base = plot_count;
        wait_plots(base + 1);
        #1 start = 1'b0;
        wait_drain();

        // Randomized requests, legal and illegal rows.
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(0, 11);
            c = $urandom_range(0, 4095);
            e = 1'($urandom_range(0, 1));
            if (r > 9) push_err();
            else push_row(r, c, e, -1);
            do_start(r, c, e);
            wait_drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
